// File: rtl/rs_syndrome_serial.sv
// Symbol-serial Reed-Solomon syndrome calculator: Horner evaluation of r(alpha^(FCR+j))
// for every syndrome in parallel, with a held output register that overlaps the next codeword.
module rs_syndrome_serial #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7,
    parameter int K            = 5,
    parameter int PRIM_POLY    = 11,
    parameter int FCR          = 1,
    localparam int NSYND       = N - K,
    localparam int CNT_W       = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sync_clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SYMBOL_WIDTH-1:0]       in_sym,
    output logic                          synd_valid,
    input  logic                          synd_ready,
    output logic [NSYND*SYMBOL_WIDTH-1:0] synd,
    output logic                          synd_zero,
    output logic [CNT_W-1:0]              sym_cnt
);

    localparam int Q = (1 << SYMBOL_WIDTH) - 1;
    localparam logic [SYMBOL_WIDTH-1:0] POLY_LO = PRIM_POLY[SYMBOL_WIDTH-1:0];
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    // Multiply by alpha (x) modulo the primitive polynomial.
    function automatic logic [SYMBOL_WIDTH-1:0] xtime(input logic [SYMBOL_WIDTH-1:0] a);
        logic [SYMBOL_WIDTH-1:0] r;
        r = a << 1;
        if (a[SYMBOL_WIDTH-1])
            r = r ^ POLY_LO;
        return r;
    endfunction

    function automatic logic [SYMBOL_WIDTH-1:0] gf_mul(input logic [SYMBOL_WIDTH-1:0] a,
                                                        input logic [SYMBOL_WIDTH-1:0] b);
        logic [SYMBOL_WIDTH-1:0] p;
        logic [SYMBOL_WIDTH-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < SYMBOL_WIDTH; i++) begin
            if (b[i])
                p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [SYMBOL_WIDTH-1:0] gf_pow(input int e);
        logic [SYMBOL_WIDTH-1:0] r;
        r = SYMBOL_WIDTH'(1);
        for (int i = 0; i < (e % Q); i++)
            r = xtime(r);
        return r;
    endfunction

    logic [NSYND*SYMBOL_WIDTH-1:0] acc_reg;
    logic [NSYND*SYMBOL_WIDTH-1:0] horner_next;
    logic [CNT_W-1:0]              sym_cnt_reg;
    logic [NSYND*SYMBOL_WIDTH-1:0] synd_reg;
    logic                          synd_valid_reg;
    logic                          synd_zero_reg;
    logic                          accept;
    logic                          is_last;

    assign is_last  = (sym_cnt_reg == LAST_IDX);
    assign in_ready = !sync_clr && !(is_last && synd_valid_reg && !synd_ready);
    assign accept   = in_valid && in_ready;

    // The first symbol of a codeword overwrites the accumulator, so no explicit clear is needed.
    generate
        for (genvar gi = 0; gi < NSYND; gi++) begin : g_root
            localparam logic [SYMBOL_WIDTH-1:0] ROOT = gf_pow(FCR + gi);
            assign horner_next[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
                (sym_cnt_reg == '0) ? in_sym
                                    : (gf_mul(acc_reg[gi*SYMBOL_WIDTH +: SYMBOL_WIDTH], ROOT) ^ in_sym);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg     <= '0;
            sym_cnt_reg <= '0;
        end else if (sync_clr) begin
            acc_reg     <= '0;
            sym_cnt_reg <= '0;
        end else if (accept) begin
            acc_reg     <= horner_next;
            sym_cnt_reg <= is_last ? '0 : sym_cnt_reg + 1'b1;
        end
    end

    // A final symbol accepted in the same cycle the held result is consumed reloads directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synd_reg       <= '0;
            synd_valid_reg <= 1'b0;
            synd_zero_reg  <= 1'b0;
        end else if (accept && is_last) begin
            synd_reg       <= horner_next;
            synd_valid_reg <= 1'b1;
            synd_zero_reg  <= (horner_next == '0);
        end else if (synd_valid_reg && synd_ready) begin
            synd_valid_reg <= 1'b0;
        end
    end

    assign synd       = synd_reg;
    assign synd_valid = synd_valid_reg;
    assign synd_zero  = synd_zero_reg;
    assign sym_cnt    = sym_cnt_reg;

endmodule

// File: tb/tb_rs_syndrome_serial.sv
// Bench for rs_syndrome_serial: directed and random codewords checked cycle by cycle against
// a reference that evaluates the received polynomial directly using log/antilog tables.
module tb_rs_syndrome_serial;

    localparam int SW  = 3;
    localparam int N   = 7;
    localparam int K   = 5;
    localparam int PP  = 11;
    localparam int FCR = 1;
    localparam int NS  = N - K;
    localparam int Q   = (1 << SW) - 1;
    localparam int CW  = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sync_clr;
    logic              in_valid;
    logic              in_ready;
    logic [SW-1:0]     in_sym;
    logic              synd_valid;
    logic              synd_ready;
    logic [NS*SW-1:0]  synd;
    logic              synd_zero;
    logic [CW-1:0]     sym_cnt;

    always #5 clk = ~clk;

    rs_syndrome_serial #(
        .SYMBOL_WIDTH(SW), .N(N), .K(K), .PRIM_POLY(PP), .FCR(FCR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .synd_valid(synd_valid), .synd_ready(synd_ready), .synd(synd),
        .synd_zero(synd_zero), .sym_cnt(sym_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    int exp_tab [Q];
    int log_tab [Q+1];

    int m_cnt;
    bit m_valid;
    bit m_zero;
    int m_synd [NS];
    int wbuf   [N];

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0)
            return 0;
        return exp_tab[(log_tab[a] + log_tab[b]) % Q];
    endfunction

    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < Q; i++) begin
            exp_tab[i] = e;
            log_tab[e] = i;
            e = e << 1;
            if ((e & (1 << SW)) != 0)
                e = e ^ PP;
        end
    endtask

    // S_j = sum over i of r_i * alpha^((FCR+j)*(N-1-i)), first received symbol is the top coefficient.
    task automatic model_eval();
        int s;
        m_zero = 1'b1;
        for (int j = 0; j < NS; j++) begin
            s = 0;
            for (int i = 0; i < N; i++)
                s = s ^ gmul(wbuf[i], exp_tab[((FCR + j) * (N - 1 - i)) % Q]);
            m_synd[j] = s;
            if (s != 0)
                m_zero = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_valid = 1'b0;
        m_zero  = 1'b0;
        for (int j = 0; j < NS; j++)
            m_synd[j] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs();
        logic [NS*SW-1:0] e;
        for (int j = 0; j < NS; j++)
            e[j*SW +: SW] = SW'(m_synd[j]);
        chk("synd_valid", 32'(synd_valid), 32'(m_valid));
        chk("synd", 32'(synd), 32'(e));
        chk("synd_zero", 32'(synd_zero), 32'(m_zero));
        chk("sym_cnt", 32'(sym_cnt), 32'(m_cnt));
    endtask

    // One clock cycle: drive, check in_ready before the edge, update the model, check after the edge.
    task automatic cycle(input bit v, input int sym, input bit rdy, input bit clr, output bit acc);
        bit exp_rdy;
        bit ohs;
        in_valid   = v;
        in_sym     = SW'(sym);
        synd_ready = rdy;
        sync_clr   = clr;
        #1;
        exp_rdy = !clr && !(m_cnt == N - 1 && m_valid && !rdy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        ohs = m_valid && rdy;
        if (ohs)
            $display("syndrome out: synd=%0h zero=%0d t=%0t", synd, synd_zero, $time);
        @(posedge clk);
        #1;
        if (ohs)
            m_valid = 1'b0;
        if (clr) begin
            m_cnt = 0;
        end else if (acc) begin
            wbuf[m_cnt] = sym;
            if (m_cnt == N - 1) begin
                model_eval();
                m_valid = 1'b1;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        chk_outputs();
    endtask

    task automatic send_word(input int syms [N], input bit rdy);
        bit acc;
        int tries;
        for (int i = 0; i < N; i++) begin
            tries = 0;
            acc   = 1'b0;
            while (!acc && tries < 20) begin
                cycle(1'b1, syms[i], rdy, 1'b0, acc);
                tries++;
            end
            n_vec++;
            assert (acc) else begin
                n_err++;
                $error("FAIL stall_timeout: symbol %0d accepted=%0d required=1", i, acc);
            end
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        chk("in_ready_rst", 32'(in_ready), 32'(!sync_clr));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int w_zero [N] = '{0, 0, 0, 0, 0, 0, 0};
        int w_hi   [N] = '{1, 0, 0, 0, 0, 0, 0};
        int w_lo   [N] = '{0, 0, 0, 0, 0, 0, 3};
        int w_a    [N];
        int w_b    [N];

        build_tables();
        rst_n      = 1'b0;
        sync_clr   = 1'b0;
        in_valid   = 1'b0;
        in_sym     = '0;
        synd_ready = 1'b1;
        #2;
        async_reset();

        // All-zero codeword.
        send_word(w_zero, 1'b1);
        chk("zero_word_synd", 32'(synd), 32'h0);
        chk("zero_word_flag", 32'(synd_zero), 32'h1);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);

        // Single error at x^6 and at x^0.
        send_word(w_hi, 1'b1);
        chk("err_x6_synd", 32'(synd), 32'h3D);
        chk("err_x6_zero", 32'(synd_zero), 32'h0);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);
        send_word(w_lo, 1'b1);
        chk("err_x0_synd", 32'(synd), 32'h1B);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);

        // Three back-to-back codewords at full rate.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++)
                w_a[i] = int'($urandom_range(0, Q));
            send_word(w_a, 1'b1);
        end
        cycle(1'b0, 0, 1'b1, 1'b0, acc);

        // Held output while the next codeword streams; stall only on the final symbol.
        for (int i = 0; i < N; i++) begin
            w_a[i] = int'($urandom_range(0, Q));
            w_b[i] = int'($urandom_range(0, Q));
        end
        send_word(w_a, 1'b1);
        for (int i = 0; i < N - 1; i++)
            cycle(1'b1, w_b[i], 1'b0, 1'b0, acc);
        cycle(1'b1, w_b[N-1], 1'b0, 1'b0, acc);
        chk("stall_last_acc", 32'(acc), 32'h0);
        cycle(1'b1, w_b[N-1], 1'b0, 1'b0, acc);
        cycle(1'b1, w_b[N-1], 1'b1, 1'b0, acc);
        chk("release_last_acc", 32'(acc), 32'h1);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);

        // Abort after three symbols, then a clean codeword.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 6, 1'b1, 1'b0, acc);
        cycle(1'b1, 6, 1'b1, 1'b1, acc);
        send_word(w_hi, 1'b1);
        chk("after_clr_synd", 32'(synd), 32'h3D);
        cycle(1'b0, 0, 1'b1, 1'b0, acc);

        // Reset pulsed mid-codeword with a result still pending.
        send_word(w_lo, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5, 1'b0, 1'b0, acc);
        async_reset();
        send_word(w_hi, 1'b1);
        chk("after_rst_synd", 32'(synd), 32'h3D);

        // Random traffic with gaps, backpressure and occasional aborts.
        for (int c = 0; c < 600; c++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, Q)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, acc);
            if (c == 300)
                async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
